aes_add_round_key_seq: RTL and testbench

Sequential, parameterised AddRoundKey engine for the AES datapath. It holds an internal round-key store of NUM_KEYS 128-bit words, loaded through a write port. It accepts a 128-bit state plus a round index over a valid/ready handshake and XORs the state with the selected round key, LANE_W bits per cycle. The result is returned over a second valid/ready handshake and feeds the inverse-cipher round controller.

---
 rtl/aes_ark_pkg.sv | 20 ++
 rtl/ark_key_store.sv | 43 ++++
 rtl/aes_add_round_key_seq.sv | 131 +++++++++++++
 tb/tb_aes_add_round_key_seq.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_ark_pkg.sv
// Shared constants, FSM state type and lane-mask helper for the AddRoundKey engine.
package aes_ark_pkg;

    localparam int AES_BLOCK_W = 128;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } ark_state_e;

    // Ones over lane [127-beat*lane_w -: lane_w]; lane 0 is the MSB lane.
    function automatic logic [AES_BLOCK_W-1:0] lane_mask(input int unsigned beat,
                                                         input int unsigned lane_w);
        logic [AES_BLOCK_W-1:0] w_top;
        w_top = ~({AES_BLOCK_W{1'b1}} >> lane_w);
        return w_top >> (beat * lane_w);
    endfunction

endpackage

// File: rtl/ark_key_store.sv
// Round-key register file: one write port, one combinational read port.
// Optional ARK_KEY_ZEROIZE_EN adds a clear-all input that overrides writes.
module ark_key_store
    import aes_ark_pkg::*;
#(
    parameter  int NUM_KEYS = 11,
    localparam int KIDX_W   = $clog2(NUM_KEYS)
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
`ifdef ARK_KEY_ZEROIZE_EN
    input  logic                   i_zeroize,
`endif
    input  logic                   i_we,
    input  logic [KIDX_W-1:0]      i_waddr,
    input  logic [AES_BLOCK_W-1:0] i_wdata,
    input  logic [KIDX_W-1:0]      i_raddr,
    output logic [AES_BLOCK_W-1:0] o_rdata
);

    logic [AES_BLOCK_W-1:0] r_mem [NUM_KEYS];
    logic                   w_clear;

`ifdef ARK_KEY_ZEROIZE_EN
    assign w_clear = !i_rst_n || i_zeroize;
`else
    assign w_clear = !i_rst_n;
`endif

    always_ff @(posedge i_clk) begin
        if (w_clear) begin
            for (int i = 0; i < NUM_KEYS; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_we && (int'(i_waddr) < NUM_KEYS)) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Out-of-range indices read as zero; the caller flags them as errors anyway.
    assign o_rdata = (int'(i_raddr) < NUM_KEYS) ? r_mem[i_raddr] : '0;

endmodule

// File: rtl/aes_add_round_key_seq.sv
// Sequential AddRoundKey: state XOR key[round], LANE_W bits per cycle, MSB lane first.
// Optional ARK_KEY_ZEROIZE_EN adds key_zeroize (clears keys, aborts a running block).
//
// Handshakes: a transfer happens on an edge where valid and ready are both 1;
// valid never depends on ready, and offered data is ignored while ready is 0.
module aes_add_round_key_seq
    import aes_ark_pkg::*;
#(
    parameter  int LANE_W   = 32,
    parameter  int NUM_KEYS = 11,
    localparam int KIDX_W   = $clog2(NUM_KEYS)
) (
    input  logic              Clk,
    input  logic              Reset_n,
`ifdef ARK_KEY_ZEROIZE_EN
    input  logic              key_zeroize,
`endif
    input  logic              key_we,
    input  logic [KIDX_W-1:0] key_waddr,
    input  logic [127:0]      key_wdata,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [127:0]      in_state,
    input  logic [KIDX_W-1:0] in_round,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [127:0]      out_state,
    output logic              out_err,
    output logic [1:0]        o_dbg_state
);

    localparam int NBEATS = AES_BLOCK_W / LANE_W;
    localparam int BEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_RUN  = RUN;
    localparam logic [1:0] ST_DONE = DONE;

    logic [1:0]        r_state;
    logic [BEAT_W-1:0] r_beat;
    logic [127:0]      r_work;
    logic [127:0]      r_key;
    logic [127:0]      r_out_state;
    logic              r_out_err;

    logic [127:0]      w_key_rdata;
    logic [127:0]      w_work_next;
    logic              w_accept;
    logic              w_round_ok;
    logic              w_last_beat;

    ark_key_store #(.NUM_KEYS(NUM_KEYS)) u_key_store (
        .i_clk     (Clk),
        .i_rst_n   (Reset_n),
`ifdef ARK_KEY_ZEROIZE_EN
        .i_zeroize (key_zeroize),
`endif
        .i_we      (key_we),
        .i_waddr   (key_waddr),
        .i_wdata   (key_wdata),
        .i_raddr   (in_round),
        .o_rdata   (w_key_rdata)
    );

    assign w_accept    = in_valid && (r_state == ST_IDLE);
    assign w_round_ok  = int'(in_round) < NUM_KEYS;
    assign w_last_beat = r_beat == BEAT_W'(NBEATS - 1);
    assign w_work_next = r_work ^ (r_key & lane_mask(32'(r_beat), LANE_W));

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_state     <= ST_IDLE;
            r_beat      <= '0;
            r_work      <= '0;
            r_key       <= '0;
            r_out_state <= '0;
            r_out_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // Snapshot reads the store before this edge's write lands.
                    if (w_accept) begin
                        r_work <= in_state;
                        r_key  <= w_key_rdata;
                        r_beat <= '0;
                        if (w_round_ok) begin
                            r_state <= ST_RUN;
                        end else begin
                            r_state     <= ST_DONE;
                            r_out_state <= in_state;
                            r_out_err   <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    r_work <= w_work_next;
                    r_beat <= r_beat + 1'b1;
                    if (w_last_beat) begin
                        r_state     <= ST_DONE;
                        r_out_state <= w_work_next;
                        r_out_err   <= 1'b0;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
`ifdef ARK_KEY_ZEROIZE_EN
            // Placed last so it wins over whatever the FSM decided this edge.
            if (key_zeroize) begin
                r_key <= '0;
                if (r_state == ST_RUN) begin
                    r_state     <= ST_DONE;
                    r_out_state <= '0;
                    r_out_err   <= 1'b1;
                end
            end
`endif
        end
    end

    assign in_ready    = (r_state == ST_IDLE);
    assign out_valid   = (r_state == ST_DONE);
    assign out_state   = r_out_state;
    assign out_err     = r_out_err;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_aes_add_round_key_seq.sv
// Bench for aes_add_round_key_seq: three instances (LANE_W 32, 8, 128) share one stimulus
// stream and are checked against a key-array reference model and an expected-result queue.
module tb_aes_add_round_key_seq;

  localparam int NI       = 3;
  localparam int NUM_KEYS = 11;
  localparam int KW       = 4;
  localparam int LW [NI]  = '{32, 8, 128};

  // ---------------- clock / reset ----------------
  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  always #5 Clk = ~Clk;

  logic          key_zeroize = 1'b0;
  logic          key_we = 1'b0;
  logic [KW-1:0] key_waddr = '0;
  logic [127:0]  key_wdata = '0;
  logic          in_valid = 1'b0;
  logic [127:0]  in_state = '0;
  logic [KW-1:0] in_round = '0;
  logic          out_ready = 1'b1;

  logic [NI-1:0] in_ready;
  logic [NI-1:0] out_valid;
  logic [NI-1:0] out_err;
  logic [127:0]  out_state [NI];
  logic [1:0]    dbg_state [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    aes_add_round_key_seq #(.LANE_W(LW[g]), .NUM_KEYS(NUM_KEYS)) u_dut (
      .Clk         (Clk),
      .Reset_n     (Reset_n),
`ifdef ARK_KEY_ZEROIZE_EN
      .key_zeroize (key_zeroize),
`endif
      .key_we      (key_we),
      .key_waddr   (key_waddr),
      .key_wdata   (key_wdata),
      .in_valid    (in_valid),
      .in_ready    (in_ready[g]),
      .in_state    (in_state),
      .in_round    (in_round),
      .out_valid   (out_valid[g]),
      .out_ready   (out_ready),
      .out_state   (out_state[g]),
      .out_err     (out_err[g]),
      .o_dbg_state (dbg_state[g])
    );
  end

  // ---------------- reference model / scoreboard ----------------
  logic [127:0] m_key [NUM_KEYS];
  logic [128:0] exp_q [$];
  int           n_cmp = 0;
  int           n_err = 0;
  int           c_lat [NI];
  logic [128:0] c_res [NI];

  task automatic check(input string tag, input logic [128:0] got, input logic [128:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Result is {err, state}.
  function automatic logic [128:0] ref_ark(input logic [127:0] st, input int rnd);
    if (rnd >= NUM_KEYS) return {1'b1, st};
    return {1'b0, st ^ m_key[rnd]};
  endfunction

  task automatic clear_model();
    for (int i = 0; i < NUM_KEYS; i++) m_key[i] = '0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic write_key(input int addr, input logic [127:0] data);
    key_we    = 1'b1;
    key_waddr = KW'(addr);
    key_wdata = data;
    tick();
    key_we = 1'b0;
    if (addr < NUM_KEYS) m_key[addr] = data;
  endtask

  task automatic wait_all_ready();
    int n = 0;
    while (in_ready !== '1 && n < 60) begin
      tick();
      n++;
    end
    if (in_ready !== '1) check("ready_timeout", {126'b0, in_ready}, {126'b0, 3'b111});
  endtask

  // Called #1 after the accept edge; latency counts edges after the accept edge.
  task automatic collect();
    logic [NI-1:0] seen = '0;
    for (int i = 0; i < NI; i++) begin
      c_lat[i] = 999;
      c_res[i] = 'x;
    end
    for (int k = 0; k <= 40; k++) begin
      for (int i = 0; i < NI; i++) begin
        if (!seen[i] && out_valid[i]) begin
          seen[i]  = 1'b1;
          c_lat[i] = k;
          c_res[i] = {out_err[i], out_state[i]};
        end
      end
      if (seen == '1) break;
      tick();
      key_we = 1'b0;
    end
  endtask

  task automatic send_block(input string tag, input logic [127:0] st, input int rnd,
                            input bit hazard);
    logic [128:0] exp;
    wait_all_ready();
    exp = ref_ark(st, rnd);
    exp_q.push_back(exp);
    in_valid = 1'b1;
    in_state = st;
    in_round = KW'(rnd);
    if (hazard) begin
      key_we    = 1'b1;
      key_waddr = '0;
      key_wdata = '1;
    end
    tick();
    in_valid = 1'b0;
    in_state = {$urandom, $urandom, $urandom, $urandom};
    in_round = KW'($urandom_range(0, 15));
    // The hazard write stays asserted through the first RUN cycle too.
    if (hazard) m_key[0] = '1;
    collect();
    exp = exp_q.pop_front();
    for (int i = 0; i < NI; i++) begin
      check($sformatf("%s_res_lw%0d", tag, LW[i]), c_res[i], exp);
      check($sformatf("%s_lat_lw%0d", tag, LW[i]), 129'(c_lat[i]),
            129'((rnd < NUM_KEYS) ? (128 / LW[i]) : 0));
    end
  endtask

  task automatic backpressure_test();
    logic [128:0] exp;
    int n = 0;
    wait_all_ready();
    out_ready = 1'b0;
    exp = ref_ark(128'h00112233_44556677_8899aabb_ccddeeff, 3);
    exp_q.push_back(exp);
    in_valid = 1'b1;
    in_state = 128'h00112233_44556677_8899aabb_ccddeeff;
    in_round = 4'd3;
    tick();
    in_valid = 1'b0;
    while (out_valid !== '1 && n < 40) begin
      tick();
      n++;
    end
    exp = exp_q.pop_front();
    for (int c = 0; c < 5; c++) begin
      in_valid = 1'b1;
      in_state = {$urandom, $urandom, $urandom, $urandom};
      in_round = 4'd0;
      check($sformatf("bp_valid_c%0d", c), {126'b0, out_valid}, {126'b0, 3'b111});
      check($sformatf("bp_ready_c%0d", c), {126'b0, in_ready}, 129'b0);
      for (int i = 0; i < NI; i++)
        check($sformatf("bp_hold_c%0d_lw%0d", c, LW[i]), {out_err[i], out_state[i]}, exp);
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tick();
    check("bp_ready_after", {126'b0, in_ready}, {126'b0, 3'b111});
    check("bp_valid_after", {126'b0, out_valid}, 129'b0);
    tick();
    check("bp_no_extra", {126'b0, out_valid}, 129'b0);
  endtask

  task automatic reset_abort_test();
    wait_all_ready();
    in_valid = 1'b1;
    in_state = {$urandom, $urandom, $urandom, $urandom};
    in_round = 4'd0;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    check("rst_in_run", {127'b0, dbg_state[0]}, 129'd1);
    Reset_n = 1'b0;
    tick();
    check("rst_ready", {126'b0, in_ready}, {126'b0, 3'b111});
    check("rst_valid", {126'b0, out_valid}, 129'b0);
    Reset_n = 1'b1;
    clear_model();
    for (int k = 0; k < 20; k++) begin
      if (out_valid !== '0) check("rst_spurious_out", {126'b0, out_valid}, 129'b0);
      tick();
    end
    // key[0] was cleared, so round 0 must pass the state through.
    send_block("rst_key0", 128'hdeadbeef_01234567_89abcdef_cafef00d, 0, 1'b0);
  endtask

`ifdef ARK_KEY_ZEROIZE_EN
  task automatic zeroize_test();
    write_key(2, {$urandom, $urandom, $urandom, $urandom});
    wait_all_ready();
    in_valid = 1'b1;
    in_state = {$urandom, $urandom, $urandom, $urandom};
    in_round = 4'd2;
    tick();
    in_valid    = 1'b0;
    key_zeroize = 1'b1;
    tick();
    key_zeroize = 1'b0;
    clear_model();
    for (int i = 0; i < NI; i++) begin
      check($sformatf("zero_valid_lw%0d", LW[i]), {128'b0, out_valid[i]}, 129'd1);
      check($sformatf("zero_res_lw%0d", LW[i]), {out_err[i], out_state[i]}, {1'b1, 128'b0});
    end
    send_block("zero_key2", 128'h55555555_aaaaaaaa_12345678_9abcdef0, 2, 1'b0);
  endtask
`endif

  // ---------------- main sequence ----------------
  initial begin
    logic [127:0] st;
    clear_model();
    tick();
    tick();
    check("reset_ready", {126'b0, in_ready}, {126'b0, 3'b111});
    check("reset_valid", {126'b0, out_valid}, 129'b0);
    check("reset_err", {126'b0, out_err}, 129'b0);
    check("reset_out0", {1'b0, out_state[0]}, 129'b0);
    Reset_n = 1'b1;
    tick();

    send_block("keys_clear", 128'h0f0e0d0c_0b0a0908_07060504_03020100, 5, 1'b0);

    write_key(0, 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c);
    send_block("fips", 128'h3243f6a8_885a308d_313198a2_e0370734, 0, 1'b0);
    for (int i = 0; i < NI; i++)
      check($sformatf("fips_const_lw%0d", LW[i]), c_res[i],
            {1'b0, 128'h193de3be_a0f4e22b_9ac68d2a_e9f84808});

    send_block("oor", 128'h01234567_89abcdef_00112233_44556677, 11, 1'b0);
    for (int i = 0; i < NI; i++)
      check($sformatf("oor_const_lw%0d", LW[i]), c_res[i],
            {1'b1, 128'h01234567_89abcdef_00112233_44556677});

    write_key(15, '1);
    send_block("hazard_old", 128'h3243f6a8_885a308d_313198a2_e0370734, 0, 1'b1);
    send_block("hazard_new", 128'h3243f6a8_885a308d_313198a2_e0370734, 0, 1'b0);

    backpressure_test();

    for (int t = 0; t < 24; t++) begin
      if ($urandom_range(0, 1) == 1)
        write_key($urandom_range(0, 15), {$urandom, $urandom, $urandom, $urandom});
      st = {$urandom, $urandom, $urandom, $urandom};
      send_block($sformatf("rand%0d", t), st, $urandom_range(0, 12), 1'b0);
    end

    reset_abort_test();
`ifdef ARK_KEY_ZEROIZE_EN
    zeroize_test();
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, compared %0d", n_cmp);
    $fatal(1, "watchdog");
  end

endmodule
